signed_mul_ctrl: RTL



---
 rtl/mul_pkg.sv | 13 +
 rtl/signed_mul_ctrl_if.sv | 14 +
 rtl/twos_negate.sv | 9 +
 rtl/signed_mul_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the signed multiply sequencer.
package mul_pkg;
   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEG,
      S_MUL,
      S_FIX,
      S_DONE
   } state_t;
endpackage

// File: rtl/signed_mul_ctrl_if.sv
// Start/operand/result handshake between the control unit and the multiply sequencer.
interface signed_mul_ctrl_if
   import mul_pkg::*;
   ();
   logic                 start;
   logic [WIDTH-1:0]     operand1;
   logic [WIDTH-1:0]     operand2;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic                 done;

   modport master (output start, operand1, operand2, input product, busy, done);
   modport slave  (input start, operand1, operand2, output product, busy, done);
endinterface

// File: rtl/twos_negate.sv
// Combinational two's-complement negation, shared by operand and product fix-up.
module twos_negate #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   assign y = ~x + W'(1);
endmodule

// File: rtl/signed_mul_ctrl.sv
// Signed WIDTH x WIDTH multiply: magnitude conversion, shift-add loop, sign fix-up.
//
//   state  | meaning
//   S_IDLE | waiting for start; latches operands and result sign
//   S_NEG  | replaces negative operands by their magnitudes, clears accumulator
//   S_MUL  | WIDTH shift-add iterations over the multiplier bits
//   S_FIX  | negates the accumulator if signs differed, registers product
//   S_DONE | one-cycle done pulse, then back to idle
module signed_mul_ctrl
   import mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   signed_mul_ctrl_if.slave  bus
);
   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;
   logic                 sign;

   logic [WIDTH-1:0]     mcand_neg;
   logic [WIDTH-1:0]     mplier_neg;
   logic [2*WIDTH-1:0]   acc_neg;
   logic [WIDTH:0]       sum;

   twos_negate #(.W(WIDTH))   u_neg_mcand  (.x(mcand),  .y(mcand_neg));
   twos_negate #(.W(WIDTH))   u_neg_mplier (.x(mplier), .y(mplier_neg));
   twos_negate #(.W(2*WIDTH)) u_neg_acc    (.x(acc),    .y(acc_neg));

   // Upper half plus multiplicand, carry kept in the extra bit.
   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (mplier[0]) begin
         sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         sign        <= 1'b0;
         bus.product <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mcand    <= bus.operand1;
                  mplier   <= bus.operand2;
                  sign     <= bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1];
                  bus.busy <= 1'b1;
                  state    <= S_NEG;
               end
            end
            S_NEG: begin
               if (mcand[WIDTH-1]) mcand <= mcand_neg;
               if (mplier[WIDTH-1]) mplier <= mplier_neg;
               acc   <= '0;
               cnt   <= CNT_W'(WIDTH);
               state <= S_MUL;
            end
            S_MUL: begin
               // Shift {carry, acc, multiplier} right; the multiplier LSB is consumed.
               {acc, mplier} <= {sum, acc[WIDTH-1:0], mplier[WIDTH-1:1]};
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= S_FIX;
            end
            S_FIX: begin
               bus.product <= sign ? acc_neg : acc;
               bus.done    <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
